// File: rtl/pc_fetch_4b.sv
// rtl/pc_fetch_4b.sv - program counter and request/ack instruction-fetch sequencer
module pc_fetch_4b #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [3:0] branch_target,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_out,
  output logic [3:0] instr_pc,
  output logic [3:0] pc,
  output logic [3:0] pc_plus1,
  output logic [3:0] branch_target_q,
  output logic       next_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] instr_out_q, instr_out_d;
  logic [3:0] instr_pc_q, instr_pc_d;
  logic [3:0] btgt_q, btgt_d;
  logic       next_sel_q, next_sel_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    btgt_d      = btgt_q;
    next_sel_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end
        if (!stall) begin
          state_d = REQ;
          addr_d  = branch_taken ? branch_target : pc_q;
        end
      end

      REQ: begin
        // Stall is ignored here: the memory handshake must complete.
        if (imem_ack && branch_taken) begin
          pc_d   = branch_target;
          addr_d = branch_target;
        end else if (imem_ack) begin
          instr_out_d = imem_data;
          instr_pc_d  = addr_q;
          pc_d        = pc_q + 4'd1;
          state_d     = ISSUE;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // The request at the old address is still outstanding; its data is dropped.
        if (branch_taken) begin
          pc_d = branch_target;
        end
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = branch_taken ? branch_target : pc_q;
        end
      end

      ISSUE: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          addr_d  = branch_target;
          state_d = REQ;
        end else if (instr_ready && !stall) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (branch_taken) begin
      btgt_d     = branch_target;
      next_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      instr_out_q <= 8'h00;
      instr_pc_q  <= 4'h0;
      btgt_q      <= 4'h0;
      next_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      btgt_q      <= btgt_d;
      next_sel_q  <= next_sel_d;
    end
  end

  assign imem_req        = (state_q == REQ) || (state_q == DRAIN);
  assign instr_valid     = (state_q == ISSUE);
  assign imem_addr       = addr_q;
  assign instr_out       = instr_out_q;
  assign instr_pc        = instr_pc_q;
  assign pc              = pc_q;
  assign pc_plus1        = pc_q + 4'd1;
  assign branch_target_q = btgt_q;
  assign next_sel        = next_sel_q;

endmodule
